// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - IF-stage program counter with next-PC selection and delay-slot tracking
// Optional macro PC_FETCH_BD_TRACK_EN enables redir_q and the IsBD_IF output.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Jump,
    input  logic [31:0] Jump_Target,
    input  logic        Br_Taken,
    input  logic [31:0] Br_Target,
    input  logic        Is_BJ_ID,
    input  logic        Exc_Req,
    input  logic        Eret_Req,
    input  logic [31:0] EPC,
    output logic [31:0] PC_IF,
    output logic [31:0] PC8_IF,
    output logic        IsBD_IF
);

    logic [31:0] r_pc;
    logic [31:0] w_next_pc;

    // Flush requests outrank Stall because the whole pipeline is being discarded.
    always_comb begin
        w_next_pc = r_pc + 32'd4;
        if (Exc_Req) begin
            w_next_pc = EXC_VECTOR;
        end else if (Eret_Req) begin
            w_next_pc = EPC;
        end else if (Stall) begin
            w_next_pc = r_pc;
        end else if (Jump) begin
            w_next_pc = Jump_Target;
        end else if (Br_Taken) begin
            w_next_pc = Br_Target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    assign PC_IF  = r_pc;
    assign PC8_IF = r_pc + 32'd8;

`ifdef PC_FETCH_BD_TRACK_EN
    logic r_redir_q;

    // A vector/EPC fetch follows a flush, so whatever sits in ID is not its branch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_redir_q <= 1'b0;
        end else if (Exc_Req || Eret_Req) begin
            r_redir_q <= 1'b1;
        end else if (!Stall) begin
            r_redir_q <= 1'b0;
        end
    end

    assign IsBD_IF = Is_BJ_ID & ~r_redir_q;
`else
    logic w_unused_bj;

    assign w_unused_bj = Is_BJ_ID;
    assign IsBD_IF     = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed scoreboard bench for pc_fetch_unit
module tb_pc_fetch_unit;

`ifdef PC_FETCH_BD_TRACK_EN
    localparam logic BD_EN = 1'b1;
`else
    localparam logic BD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall;
    logic        Jump;
    logic [31:0] Jump_Target;
    logic        Br_Taken;
    logic [31:0] Br_Target;
    logic        Is_BJ_ID;
    logic        Exc_Req;
    logic        Eret_Req;
    logic [31:0] EPC;
    logic [31:0] PC_IF;
    logic [31:0] PC8_IF;
    logic        IsBD_IF;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    pc_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .Stall       (Stall),
        .Jump        (Jump),
        .Jump_Target (Jump_Target),
        .Br_Taken    (Br_Taken),
        .Br_Target   (Br_Target),
        .Is_BJ_ID    (Is_BJ_ID),
        .Exc_Req     (Exc_Req),
        .Eret_Req    (Eret_Req),
        .EPC         (EPC),
        .PC_IF       (PC_IF),
        .PC8_IF      (PC8_IF),
        .IsBD_IF     (IsBD_IF)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        reset = 1'b0; Stall = 1'b0; Jump = 1'b0; Br_Taken = 1'b0;
        Is_BJ_ID = 1'b0; Exc_Req = 1'b0; Eret_Req = 1'b0;
        Jump_Target = 32'h0; Br_Target = 32'h0; EPC = 32'h0;
    endtask

    // Push the expected post-edge PC, advance one edge, then pop and compare.
    task automatic tick(input string tag, input logic [31:0] exp_pc);
        logic [31:0] e;
        exp_q.push_back(exp_pc);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_pc"}, PC_IF, e);
            chk({tag, "_pc8"}, PC8_IF, e + 32'd8);
        end
    endtask

    task automatic chk_bd(input string tag, input logic exp_raw);
        #1;
        chk({tag, "_bd"}, {31'd0, IsBD_IF}, {31'd0, exp_raw & BD_EN});
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        tick("reset", 32'h3000);
        chk_bd("reset", 1'b0);
        reset = 1'b0;
        tick("seq1", 32'h3004);
        tick("seq2", 32'h3008);
        tick("seq3", 32'h300C);
        chk_bd("seq3", 1'b0);
        tick("seq4", 32'h3010);

        Br_Taken = 1'b1; Br_Target = 32'h3040; Is_BJ_ID = 1'b1;
        chk_bd("br_slot", 1'b1);
        tick("br", 32'h3040);
        clear_inputs();

        Jump = 1'b1; Jump_Target = 32'h3020;
        tick("j3020", 32'h3020);
        Stall = 1'b1; Jump_Target = 32'h3100;
        for (int i = 0; i < 3; i++) tick("stall", 32'h3020);
        Stall = 1'b0;
        tick("stall_rel", 32'h3100);
        clear_inputs();
        tick("seq5", 32'h3104);

        Exc_Req = 1'b1; Stall = 1'b1; Is_BJ_ID = 1'b1;
        tick("exc_stall", 32'h4180);
        Exc_Req = 1'b0;
        chk_bd("exc_redir", 1'b0);
        tick("redir_hold", 32'h4180);
        chk_bd("redir_hold", 1'b0);
        Stall = 1'b0;
        tick("redir_clr", 32'h4184);
        chk_bd("redir_clr", 1'b1);
        clear_inputs();

        Eret_Req = 1'b1; EPC = 32'h3002;
        tick("eret", 32'h3002);
        Exc_Req = 1'b1;
        tick("exc_eret", 32'h4180);
        clear_inputs();

        Jump = 1'b1; Jump_Target = 32'hFFFF_FFFC;
        tick("j_top", 32'hFFFF_FFFC);
        clear_inputs();
        tick("wrap", 32'h0000_0000);

        Jump = 1'b1; Jump_Target = 32'h3200; Br_Taken = 1'b1; Br_Target = 32'h3300;
        tick("j_over_br", 32'h3200);
        clear_inputs();

        Jump = 1'b1; Jump_Target = 32'h3050;
        tick("j3050", 32'h3050);
        clear_inputs();
        reset = 1'b1; Exc_Req = 1'b1; Is_BJ_ID = 1'b1;
        tick("rst_exc", 32'h3000);
        chk_bd("rst_exc", 1'b1);
        reset = 1'b0;
        tick("exc_after_rst", 32'h4180);
        clear_inputs();
        tick("seq6", 32'h4184);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
